// File: rtl/priority_encoder_seq.sv
// Registered priority encoder: merges requests into a pending set and issues one index per
// valid/ready transfer. Define PRIORITY_ENC_RR_EN for round-robin instead of fixed MSB-first.
module priority_encoder_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] req_in,
    input  logic             ready,
    output logic             valid,
    output logic [IDXW-1:0]  idx_out,
    output logic [IDXW:0]    pend_cnt
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] cand;
    logic [IDXW-1:0]  winner;
    logic [IDXW:0]    cnt_d;
    logic             xfer, load, any;

`ifdef PRIORITY_ENC_RR_EN
    logic [IDXW-1:0] ptr_q;

    // Descend from ptr-1, wrapping below 0 to WIDTH-1; first set bit wins.
    always_comb begin
        int pos;
        logic found;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            pos = int'(ptr_q) - 1 - k;
            if (pos < 0) pos = pos + int'(WIDTH);
            if (!found && cand[pos]) begin
                winner = IDXW'(pos);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (cand[i]) winner = IDXW'(i);
        end
    end
`endif

    assign xfer = valid && ready;
    assign load = en && !clear && (!valid || ready);
    assign cand = pending_q | (en ? req_in : '0);
    assign any  = |cand;

    always_comb begin
        pending_d = cand;
        if (clear) begin
            pending_d = '0;
        end else if (load) begin
            pending_d = any ? (cand & ~(WIDTH'(1) << winner)) : '0;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d = cnt_d + (IDXW+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            idx_out   <= '0;
            pending_q <= '0;
            pend_cnt  <= '0;
`ifdef PRIORITY_ENC_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            pending_q <= pending_d;
            pend_cnt  <= cnt_d;
            if (load) begin
                valid <= any;
                if (any) begin
                    idx_out <= winner;
`ifdef PRIORITY_ENC_RR_EN
                    ptr_q   <= winner;
`endif
                end
            end else if (xfer) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/priority_encoder_seq.md
Name: priority_encoder_seq

Overview:
Parametrised, registered successor to the team's 8-to-3 priority encoder. Accumulates request bits into a pending register and issues them one at a time as encoded indices over a valid/ready handshake, highest bit index first. Sits between multi-source event/interrupt lines and a single consumer that services one source per transfer.

Parameters:
WIDTH, 8, number of request lines (>=2)
IDXW, $clog2(WIDTH), width of encoded index (3 for WIDTH=8)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  enable; gates request capture and output loading
clear  input  1  synchronous flush of pending requests
req_in  input  WIDTH  request lines; bit i high = source i requests service
ready  input  1  consumer accepts idx_out this cycle
valid  output  1  idx_out holds an issued index
idx_out  output  IDXW  encoded index of issued source
pend_cnt  output  IDXW+1  popcount of pending register (not counting the issued index)

Behaviour:
- Reset (rst=1 at edge): valid=0, idx_out=0, pending=0, pend_cnt=0, RR pointer=0; overrides all other inputs.
- xfer = valid && ready. load = en && !clear && (!valid || ready).
- cand = pending | (en ? req_in : 0).
- Priority (base): highest set bit of cand wins (bit WIDTH-1 highest), matching the 8-to-3 encoder.
- On load with cand != 0: idx_out <= winner; valid <= 1; pending <= cand with winner bit cleared. The index is claimed out of pending when loaded, not when accepted.
- On load with cand == 0: valid <= 0; pending stays 0.
- No load, no clear: pending <= cand (requests merge); idx_out and valid held, except xfer sets valid <= 0.
- en=0: req_in ignored, no new load. An outstanding valid still completes on ready (valid <= 0), and pending is held.
- clear=1 (with rst=0): pending <= 0, and req_in for that cycle is discarded. Output register obeys only the handshake (xfer drops valid). No load that cycle.
- Re-request of a pending bit merges (no counting). Re-request of the bit currently in idx_out is queued in pending and issued again later.
- Latency: request at cycle t with idle output gives valid at t+1. Back-to-back issue is possible every cycle while ready=1.
- pend_cnt is a registered popcount of the post-update pending value, so it is consistent with pending every cycle.
- idx_out is meaningful only while valid=1. It retains its last value when valid=0.

Optional Feature:
PRIORITY_ENC_RR_EN
- Defined: round-robin priority. A pointer holds the last issued index and updates on each load with cand != 0. The search starts at (pointer-1) mod WIDTH and descends, wrapping from 0 to WIDTH-1. Because the pointer resets to 0, the first search starts at WIDTH-1, identical to fixed priority. Prevents starvation.
- Undefined: fixed MSB-first priority. No pointer register is present.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req_in=8'hFF, en=1 -> valid=0, idx_out=0, pend_cnt=0. First issue occurs one cycle after rst drops.
2. Burst: en=1, ready=1, req_in=8'b11010101 for one cycle then 0 -> idx_out 7,6,4,2,0 on consecutive cycles with valid=1, pend_cnt 4,3,2,1,0, then valid=0.
3. Backpressure: ready=0, req_in=8'b00000110 one cycle -> valid=1, idx_out=2 held, pend_cnt=1. Raise ready -> next cycle idx_out=1, pend_cnt=0, then valid=0.
4. Enable/clear: en=0 with req_in=8'h80 -> no valid, pend_cnt=0. Load pending 8'b00111000 while ready=0 (idx_out=5, pend_cnt=2). Pulse clear with req_in=8'h01 -> pend_cnt=0, idx_out=5 still valid. After ready, valid=0 and no index 0 is issued.
5. Starvation/RR: req_in=8'b10000001 held every cycle, ready=1 -> without macro idx_out=7 every cycle; with PRIORITY_ENC_RR_EN idx_out alternates 7,0,7,0.
6. Re-request: ready=0 with idx_out=3 valid, req_in=8'b00001000 -> pend_cnt=1. After ready, idx_out=3 is issued a second time.
